// File: rtl/qs_enqueue_if.sv
// Word stream into the quicksort enqueue stage.
// Source drives vld/w/last, the stage returns rdy.
interface qs_enqueue_if #(
   parameter int W = 32
) ();
   logic         in_vld;
   logic [W-1:0] in_w;
   logic         in_last;
   logic         in_rdy;

   modport master (
      output in_vld, in_w, in_last,
      input  in_rdy
   );

   modport slave (
      input  in_vld, in_w, in_last,
      output in_rdy
   );
endinterface

// File: rtl/qs_enqueue.sv
// Quicksort ingress: claims an idle bank round-robin,
// streams words into its RAM, commits count and overflow flag.
module qs_enqueue #(
   parameter int N      = 16,
   parameter int W      = 32,
   parameter int BANK_N = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   qs_enqueue_if.slave               in_if,
   input  logic [BANK_N-1:0]         bank_idle,
   output logic                      bank_claim,
   output logic [$clog2(BANK_N)-1:0] bank_sel,
   output logic                      bank_wr_en,
   output logic [$clog2(N)-1:0]      bank_wr_addr,
   output logic [W-1:0]              bank_wr_data,
   output logic                      bank_commit,
   output logic [$clog2(N):0]        bank_commit_n,
   output logic                      bank_commit_error,
   output logic                      busy
);

   localparam int AW = $clog2(N);
   localparam int CW = AW + 1;
   localparam int SW = $clog2(BANK_N);

   typedef enum logic [2:0] {
      ENQUEUE_FSM_IDLE = 3'b000,
      ENQUEUE_FSM_LOAD = 3'b101
   } state_t;

   state_t          state, state_nx;
   logic            rdy, rdy_nx;
   logic            claim_nx;
   logic [SW-1:0]   sel_nx;
   logic            wr_en_nx;
   logic [AW-1:0]   wr_addr_nx;
   logic [W-1:0]    wr_data_nx;
   logic            commit_nx;
   logic [CW-1:0]   commit_cnt_nx;
   logic            commit_err_nx;
   logic [SW-1:0]   rr, rr_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            err, err_nx;
   logic            found;
   logic [SW-1:0]   pick;
   logic            accept;
   int              idx;

   assign in_if.in_rdy = rdy;
   assign busy         = state[2];
   assign accept       = in_if.in_vld & rdy;

   // State and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ENQUEUE_FSM_IDLE;
         rdy               <= 1'b0;
         bank_claim        <= 1'b0;
         bank_sel          <= '0;
         bank_wr_en        <= 1'b0;
         bank_wr_addr      <= '0;
         bank_wr_data      <= '0;
         bank_commit       <= 1'b0;
         bank_commit_n     <= '0;
         bank_commit_error <= 1'b0;
         rr                <= '0;
         cnt               <= '0;
         err               <= 1'b0;
      end else begin
         state             <= state_nx;
         rdy               <= rdy_nx;
         bank_claim        <= claim_nx;
         bank_sel          <= sel_nx;
         bank_wr_en        <= wr_en_nx;
         bank_wr_addr      <= wr_addr_nx;
         bank_wr_data      <= wr_data_nx;
         bank_commit       <= commit_nx;
         bank_commit_n     <= commit_cnt_nx;
         bank_commit_error <= commit_err_nx;
         rr                <= rr_nx;
         cnt               <= cnt_nx;
         err               <= err_nx;
      end
   end

   // Bank search from rr, next-state and output decode
   always_comb begin
      state_nx      = state;
      rdy_nx        = rdy;
      claim_nx      = 1'b0;
      sel_nx        = bank_sel;
      wr_en_nx      = 1'b0;
      wr_addr_nx    = bank_wr_addr;
      wr_data_nx    = bank_wr_data;
      commit_nx     = 1'b0;
      commit_cnt_nx = bank_commit_n;
      commit_err_nx = bank_commit_error;
      rr_nx         = rr;
      cnt_nx        = cnt;
      err_nx        = err;
      found         = 1'b0;
      pick          = '0;
      idx           = 0;

      // descending scan so the lowest offset from rr wins
      for (int i = BANK_N - 1; i >= 0; i--) begin
         idx = (int'(rr) + i) % BANK_N;
         if (bank_idle[idx]) begin
            found = 1'b1;
            pick  = SW'(idx);
         end
      end

      unique case (state)
         ENQUEUE_FSM_IDLE: begin
            rdy_nx = 1'b0;
            if (found) begin
               state_nx = ENQUEUE_FSM_LOAD;
               sel_nx   = pick;
               claim_nx = 1'b1;
               cnt_nx   = '0;
               err_nx   = 1'b0;
               rdy_nx   = 1'b1;
            end
         end
         ENQUEUE_FSM_LOAD: begin
            rdy_nx = 1'b1;
            if (accept) begin
               if (cnt < CW'(N)) begin
                  wr_en_nx   = 1'b1;
                  wr_addr_nx = cnt[AW-1:0];
                  wr_data_nx = in_if.in_w;
                  cnt_nx     = cnt + 1'b1;
               end else begin
                  err_nx = 1'b1;
               end
               if (in_if.in_last) begin
                  state_nx      = ENQUEUE_FSM_IDLE;
                  rdy_nx        = 1'b0;
                  commit_nx     = 1'b1;
                  commit_cnt_nx = cnt_nx;
                  commit_err_nx = err_nx;
                  if (bank_sel == SW'(BANK_N - 1))
                     rr_nx = '0;
                  else
                     rr_nx = bank_sel + 1'b1;
               end
            end
         end
         default: begin
            state_nx = ENQUEUE_FSM_IDLE;
            rdy_nx   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_qs_enqueue.sv
// Directed bench for qs_enqueue: frames, overflow,
// no-idle stall, back-to-back singles, mid-frame reset.
module tb_qs_enqueue;

   logic        clk;
   logic        rst;
   logic [1:0]  bank_idle;
   logic        bank_claim;
   logic [0:0]  bank_sel;
   logic        bank_wr_en;
   logic [3:0]  bank_wr_addr;
   logic [31:0] bank_wr_data;
   logic        bank_commit;
   logic [4:0]  bank_commit_n;
   logic        bank_commit_error;
   logic        busy;

   int total = 0;
   int bad   = 0;

   int          wa_q[$];
   logic [31:0] wd_q[$];
   int          commit_cnt = 0;
   int          nacc_wr    = 0;
   logic        prev_acc   = 1'b0;

   qs_enqueue_if #(.W(32)) ifc ();

   qs_enqueue #(.N(16), .W(32), .BANK_N(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .in_if             (ifc.slave),
      .bank_idle         (bank_idle),
      .bank_claim        (bank_claim),
      .bank_sel          (bank_sel),
      .bank_wr_en        (bank_wr_en),
      .bank_wr_addr      (bank_wr_addr),
      .bank_wr_data      (bank_wr_data),
      .bank_commit       (bank_commit),
      .bank_commit_n     (bank_commit_n),
      .bank_commit_error (bank_commit_error),
      .busy              (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // write log and write-without-accept detector
   always @(negedge clk) begin
      if (bank_wr_en) begin
         wa_q.push_back(int'(bank_wr_addr));
         wd_q.push_back(bank_wr_data);
         if (!prev_acc) nacc_wr++;
      end
      if (bank_commit) commit_cnt++;
      prev_acc = ifc.in_vld && ifc.in_rdy;
   end

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"},   64'(ifc.in_rdy), 64'd0);
      chk({tag, "_claim"}, 64'(bank_claim), 64'd0);
      chk({tag, "_wren"},  64'(bank_wr_en), 64'd0);
      chk({tag, "_cmt"},   64'(bank_commit), 64'd0);
      chk({tag, "_cerr"},  64'(bank_commit_error), 64'd0);
      chk({tag, "_busy"},  64'(busy), 64'd0);
      chk({tag, "_sel"},   64'(bank_sel), 64'd0);
      chk({tag, "_addr"},  64'(bank_wr_addr), 64'd0);
      chk({tag, "_data"},  64'(bank_wr_data), 64'd0);
      chk({tag, "_cn"},    64'(bank_commit_n), 64'd0);
   endtask

   task automatic chk_claim(input string tag, input int sel);
      chk({tag, "_claim"}, 64'(bank_claim), 64'd1);
      chk({tag, "_sel"},   64'(bank_sel), 64'(sel));
      chk({tag, "_rdy"},   64'(ifc.in_rdy), 64'd1);
      chk({tag, "_busy"},  64'(busy), 64'd1);
   endtask

   task automatic chk_commit(input string tag, input int n,
                             input int e, input int sel);
      chk({tag, "_cmt"},  64'(bank_commit), 64'd1);
      chk({tag, "_cn"},   64'(bank_commit_n), 64'(n));
      chk({tag, "_cerr"}, 64'(bank_commit_error), 64'(e));
      chk({tag, "_csel"}, 64'(bank_sel), 64'(sel));
      chk({tag, "_crdy"}, 64'(ifc.in_rdy), 64'd0);
      chk({tag, "_cbsy"}, 64'(busy), 64'd0);
   endtask

   task automatic chk_writes(input string tag, input int n,
                             input logic [31:0] base);
      int errs;
      errs = 0;
      chk({tag, "_nwr"}, 64'(wa_q.size()), 64'(n));
      for (int i = 0; i < n && i < wa_q.size(); i++) begin
         if (wa_q[i] != i || wd_q[i] !== base + 32'(i))
            errs++;
      end
      chk({tag, "_wrdata"}, 64'(errs), 64'd0);
      wa_q.delete();
      wd_q.delete();
   endtask

   // returns one cycle after the final beat is accepted
   task automatic send_frame(input int n, input logic [31:0] base,
                             input bit gaps, input bit last);
      int b;
      for (int k = 0; k < n; k++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            ifc.in_vld = 1'b0;
            step;
         end
         ifc.in_vld  = 1'b1;
         ifc.in_w    = base + 32'(k);
         ifc.in_last = last && (k == n - 1);
         b = 0;
         while (!ifc.in_rdy && b < 40) begin
            step;
            b++;
         end
         if (!ifc.in_rdy)
            chk("rdy_timeout", 64'(ifc.in_rdy), 64'd1);
         step;
      end
      ifc.in_vld  = 1'b0;
      ifc.in_last = 1'b0;
   endtask

   int          sz[6] = '{1, 1, 1, 1, 4, 3};
   int          prev_n;
   logic [31:0] prev_base;
   logic [31:0] fb;
   int          snap;

   initial begin
      rst         = 1'b1;
      bank_idle   = 2'b11;
      ifc.in_vld  = 1'b0;
      ifc.in_w    = '0;
      ifc.in_last = 1'b0;
      repeat (3) step;
      chk_reset("rst0");

      // frame 1: 16 words into bank 0
      rst = 1'b0;
      step;
      chk_claim("t1", 0);
      send_frame(16, 32'd0, 1'b0, 1'b1);
      chk_commit("t1", 16, 0, 0);
      chk("t1_lastaddr", 64'(bank_wr_addr), 64'd15);

      // frame 2: bank 0 now busy, round-robin picks bank 1
      bank_idle = 2'b10;
      step;
      chk_claim("t2", 1);
      chk_writes("t1", 16, 32'd0);
      send_frame(3, 32'hA, 1'b0, 1'b1);
      chk_commit("t2", 3, 0, 1);

      // overflow: 20 words, pointer wrapped back to 0
      bank_idle = 2'b01;
      step;
      chk_claim("t3", 0);
      chk_writes("t2", 3, 32'hA);
      send_frame(20, 32'h100, 1'b0, 1'b1);
      chk_commit("t3", 16, 1, 0);

      // no bank idle, source waiting
      bank_idle   = 2'b00;
      ifc.in_vld  = 1'b1;
      ifc.in_w    = 32'hBEEF;
      ifc.in_last = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step;
         chk("t4_rdy", 64'(ifc.in_rdy), 64'd0);
         chk("t4_claim", 64'(bank_claim), 64'd0);
      end
      chk_writes("t3", 16, 32'h100);
      bank_idle = 2'b01;
      step;
      chk_claim("t4", 0);
      step;
      chk_commit("t4", 1, 0, 0);
      ifc.in_vld  = 1'b0;
      ifc.in_last = 1'b0;

      // back-to-back frames, bank_idle held, random gaps
      bank_idle = 2'b11;
      prev_n    = 1;
      prev_base = 32'hBEEF;
      for (int f = 0; f < 6; f++) begin
         step;
         chk_claim("t5", (f % 2 == 0) ? 1 : 0);
         chk_writes("t5p", prev_n, prev_base);
         fb = 32'h5000_0000 + 32'(f * 16);
         send_frame(sz[f], fb, 1'b1, 1'b1);
         chk_commit("t5", sz[f], 0, (f % 2 == 0) ? 1 : 0);
         prev_n    = sz[f];
         prev_base = fb;
      end

      // mid-frame reset after 5th accepted word
      step;
      chk_claim("t6a", 1);
      chk_writes("t5l", prev_n, prev_base);
      send_frame(5, 32'h700, 1'b0, 1'b0);
      snap = commit_cnt;
      rst  = 1'b1;
      step;
      chk_reset("rst1");
      rst = 1'b0;
      step;
      chk_claim("t6b", 0);
      chk("t6_nocmt", 64'(commit_cnt), 64'(snap));
      chk_writes("t6p", 5, 32'h700);
      send_frame(2, 32'h800, 1'b0, 1'b1);
      chk_commit("t6", 2, 0, 0);
      step;
      chk_writes("t6", 2, 32'h800);

      chk("wr_noacc", 64'(nacc_wr), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
